// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: widths, reset PC, NOP encoding,
// trap bit positions and the fetch FSM state encoding.
package if_fetch_pkg;

    localparam int unsigned Xlen    = 32;
    localparam int unsigned InstLen = 32;
    localparam int unsigned TrapLen = 8;

    localparam logic [Xlen-1:0]    PcResetAddr = 32'h8000_0000;
    localparam logic [InstLen-1:0] InstNop     = 32'h0000_0013;

    // Bit positions inside the trap bus
    localparam int unsigned TrapInstMisalign    = 0;
    localparam int unsigned TrapInstAccessFault = 1;

    typedef logic [TrapLen-1:0] trap_bus_t;

    localparam trap_bus_t TrapMaskMisalign    = trap_bus_t'(1) << TrapInstMisalign;
    localparam trap_bus_t TrapMaskAccessFault = trap_bus_t'(1) << TrapInstAccessFault;

    typedef enum logic [1:0] {
        IfFsmIdle = 2'b00,
        IfFsmWait = 2'b01,
        IfFsmDrop = 2'b10,
        IfFsmTrap = 2'b11
    } if_fsm_e;

    typedef struct packed {
        logic [Xlen-1:0]    addr;
        logic [InstLen-1:0] data;
        trap_bus_t          trap;
    } fetch_slot_t;

endpackage

// File: rtl/if_fetch_slot.sv
// One-entry holding register for a fetched instruction; shows the bubble encoding when empty.
module if_fetch_slot
    import if_fetch_pkg::*;
#(
    parameter logic [Xlen-1:0] BUBBLE_PC = PcResetAddr - 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  fetch_slot_t load_data,
    input  logic        consume,
    input  logic        clear,
    output logic        valid,
    output fetch_slot_t slot
);

    localparam fetch_slot_t Bubble = '{addr: BUBBLE_PC, data: InstNop, trap: '0};

    logic        valid_q, valid_d;
    fetch_slot_t slot_q;

    // clear beats load, load beats consume (refill in the same cycle keeps it full)
    always_comb begin
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            slot_q  <= Bubble;
        end else begin
            valid_q <= valid_d;
            if (load && !clear) begin
                slot_q <= load_data;
            end
        end
    end

    assign valid = valid_q;
    assign slot  = valid_q ? slot_q : Bubble;

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the PC, keeps at most one imem request in flight and holds one fetched
// instruction for IF/ID. Redirects flush the slot and abandon any in-flight response.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [Xlen-1:0] RESET_PC  = PcResetAddr,
    parameter logic [Xlen-1:0] BUBBLE_PC = PcResetAddr - 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_valid_i,
    input  logic [Xlen-1:0]    redirect_pc_i,
    output logic               req_valid_o,
    output logic [Xlen-1:0]    req_addr_o,
    input  logic               req_ready_i,
    input  logic               resp_valid_i,
    input  logic [InstLen-1:0] resp_data_i,
    input  logic               resp_err_i,
    output logic [Xlen-1:0]    inst_addr_if_o,
    output logic [InstLen-1:0] inst_data_if_o,
    output trap_bus_t          trap_bus_if_o
);

    if_fsm_e         state_q, state_d;
    logic [Xlen-1:0] pc_q, pc_d;

    logic        slot_valid;
    fetch_slot_t slot_out;
    fetch_slot_t slot_in;
    logic        slot_load;
    logic        slot_clear;
    logic        consume;
    logic        slot_free;
    logic        pc_misaligned;
    logic        handshake;
    logic        outstanding;

    assign consume       = slot_valid && !stall_i;
    assign slot_free     = !slot_valid || consume;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
    assign handshake     = req_valid_o && req_ready_i;
    assign slot_clear    = redirect_valid_i;

    // A request is still owed a response after this edge unless it returns now
    assign outstanding = (((state_q == IfFsmWait) || (state_q == IfFsmDrop)) && !resp_valid_i)
                         || handshake;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IfFsmIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IfFsmIdle: begin
                if (pc_misaligned) begin
                    if (slot_free) begin
                        state_d = IfFsmTrap;
                    end
                end else if (handshake) begin
                    state_d = IfFsmWait;
                end
            end
            IfFsmWait: begin
                if (resp_valid_i) begin
                    if (resp_err_i) begin
                        state_d = IfFsmTrap;
                    end else begin
                        state_d = IfFsmIdle;
                        pc_d    = pc_q + Xlen'(4);
                    end
                end
            end
            IfFsmDrop: begin
                if (resp_valid_i) begin
                    state_d = IfFsmIdle;
                end
            end
            IfFsmTrap: begin
                state_d = IfFsmTrap;
            end
            default: begin
                state_d = IfFsmIdle;
            end
        endcase

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            state_d = outstanding ? IfFsmDrop : IfFsmIdle;
        end
    end

    // Misaligned PCs wait for a free slot so a stalled instruction is never overwritten
    always_comb begin
        req_valid_o = (state_q == IfFsmIdle) && !pc_misaligned && slot_free;
        slot_load   = 1'b0;
        slot_in     = '{addr: pc_q, data: resp_data_i, trap: '0};
        unique case (state_q)
            IfFsmIdle: begin
                if (pc_misaligned && slot_free) begin
                    slot_load = 1'b1;
                    slot_in   = '{addr: pc_q, data: InstNop, trap: TrapMaskMisalign};
                end
            end
            IfFsmWait: begin
                if (resp_valid_i) begin
                    slot_load = 1'b1;
                    if (resp_err_i) begin
                        slot_in = '{addr: pc_q, data: InstNop, trap: TrapMaskAccessFault};
                    end
                end
            end
            default: begin
                slot_load = 1'b0;
            end
        endcase
    end

    assign req_addr_o = pc_q;

    if_fetch_slot #(
        .BUBBLE_PC (BUBBLE_PC)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_data (slot_in),
        .consume   (consume),
        .clear     (slot_clear),
        .valid     (slot_valid),
        .slot      (slot_out)
    );

    assign inst_addr_if_o = slot_out.addr;
    assign inst_data_if_o = slot_out.data;
    assign trap_bus_if_o  = slot_out.trap;

    // A response in WAIT must find the slot empty; requests are only issued into a free slot
    assert property (@(posedge clk) disable iff (!rst)
        (state_q == IfFsmWait) |-> !slot_valid);

    assert property (@(posedge clk) disable iff (!rst)
        req_valid_o |-> ((state_q == IfFsmIdle) && !pc_misaligned));

    assert property (@(posedge clk) disable iff (!rst)
        (slot_valid && stall_i && !redirect_valid_i) |=> slot_valid);

endmodule

// File: tb/tb_if_fetch.sv
// Randomised and directed bench for if_fetch with a transaction-level reference model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RstPc = 32'h8000_0000;
    localparam logic [31:0] BubPc = 32'h7fff_fffc;
    localparam logic [31:0] Nop   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, req_ready, resp_valid, resp_err, req_valid;
    logic [31:0] redirect_pc, req_addr, resp_data, inst_addr, inst_data;
    logic [7:0]  trap_bus;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC  (RstPc),
        .BUBBLE_PC (BubPc)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_valid_i (redirect),
        .redirect_pc_i    (redirect_pc),
        .req_valid_o      (req_valid),
        .req_addr_o       (req_addr),
        .req_ready_i      (req_ready),
        .resp_valid_i     (resp_valid),
        .resp_data_i      (resp_data),
        .resp_err_i       (resp_err),
        .inst_addr_if_o   (inst_addr),
        .inst_data_if_o   (inst_data),
        .trap_bus_if_o    (trap_bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    // Model: slot contents, pc, in-flight request, abandoned-response flag, halted on trap
    bit          m_sv, m_busy, m_discard, m_halted;
    logic [31:0] m_sa, m_sd, m_pc;
    logic [7:0]  m_st;

    // imem model
    bit          im_pend;
    int          im_cnt;
    logic [31:0] im_addr;
    logic [31:0] err_addr = 32'hffff_ffff;
    int          lat_next = 0;
    bit          lat_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic bit m_req();
        return !m_busy && !m_halted && (m_pc[1:0] == 2'b00) && (!m_sv || !stall);
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    always @(negedge clk) begin
        if (checking && rst) begin
            check("inst_addr", inst_addr, m_sv ? m_sa : BubPc);
            check("inst_data", inst_data, m_sv ? m_sd : Nop);
            check("trap_bus", {24'b0, trap_bus}, m_sv ? {24'b0, m_st} : 32'b0);
            check("req_valid", {31'b0, req_valid}, {31'b0, m_req()});
            if (m_req()) check("req_addr", req_addr, m_pc);
        end
    end

    task automatic step();
        bit          acc, consume, sfree, outst;
        logic [31:0] pc0;
        @(posedge clk);
        #1;
        acc     = rst && m_req() && req_ready;
        pc0     = m_pc;
        consume = m_sv && !stall;
        sfree   = !m_sv || consume;
        if (!rst) begin
            m_sv = 0; m_pc = RstPc; m_busy = 0; m_discard = 0; m_halted = 0;
        end else if (redirect) begin
            outst     = (m_busy && !resp_valid) || acc;
            m_busy    = outst;
            m_discard = outst;
            m_pc      = redirect_pc;
            m_sv      = 0;
            m_halted  = 0;
        end else begin
            if (consume) m_sv = 0;
            if (m_busy) begin
                if (resp_valid) begin
                    m_busy = 0;
                    if (!m_discard) begin
                        m_sv = 1;
                        m_sa = m_pc;
                        if (resp_err) begin
                            m_sd = Nop; m_st = 8'h02; m_halted = 1;
                        end else begin
                            m_sd = resp_data; m_st = 8'h00; m_pc = m_pc + 32'd4;
                        end
                    end
                    m_discard = 0;
                end
            end else if (!m_halted) begin
                if (m_pc[1:0] != 2'b00) begin
                    if (sfree) begin
                        m_sv = 1; m_sa = m_pc; m_sd = Nop; m_st = 8'h01; m_halted = 1;
                    end
                end else if (acc) begin
                    m_busy = 1;
                end
            end
        end
        resp_valid = 0;
        resp_err   = 0;
        resp_data  = 32'h0;
        if (acc) begin
            im_pend = 1;
            im_addr = pc0;
            im_cnt  = lat_rand ? int'($urandom_range(0, 2)) : lat_next;
        end
        if (im_pend) begin
            if (im_cnt == 0) begin
                resp_valid = 1;
                resp_data  = mem_data(im_addr);
                resp_err   = (im_addr == err_addr);
                im_pend    = 0;
            end else begin
                im_cnt--;
            end
        end
        cyc++;
    endtask

    task automatic wait_slot(input string name, input int max);
        int i = 0;
        while (!m_sv && i < max) begin
            step();
            i++;
        end
        if (!m_sv) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect    = 1;
        redirect_pc = target;
        step();
        redirect = 0;
    endtask

    initial begin
        rst = 0; stall = 0; redirect = 0; redirect_pc = 0; req_ready = 0;
        resp_valid = 0; resp_err = 0; resp_data = 0; im_pend = 0;
        repeat (3) step();
        rst = 1;
        checking = 1;
        req_ready = 1;
        #1;
        // 1: bubble first, then one instruction every two cycles
        check("t1_bubble_addr", inst_addr, 32'h7fff_fffc);
        check("t1_bubble_data", inst_data, 32'h0000_0013);
        check("t1_first_req", {31'b0, req_valid}, 32'd1);
        check("t1_first_addr", req_addr, 32'h8000_0000);
        step(); step();
        check("t1_inst0_addr", inst_addr, 32'h8000_0000);
        check("t1_inst0_data", inst_data, 32'h0000_0013);
        step();
        check("t1_gap_bubble", inst_addr, 32'h7fff_fffc);
        step();
        check("t1_inst1_addr", inst_addr, 32'h8000_0004);
        check("t1_inst1_data", inst_data, 32'h0004_0013);
        // 2: stall three cycles with the slot full
        stall = 1;
        #1;
        check("t2_req_blocked", {31'b0, req_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_frozen", inst_addr, 32'h8000_0004);
        end
        stall = 0;
        step();
        wait_slot("t2_next", 10);
        check("t2_after_release", inst_addr, 32'h8000_0008);
        // 3: redirect while waiting; response arrives later and is dropped
        lat_next = 2;
        step();
        pulse_redirect(32'h8000_0100);
        lat_next = 0;
        check("t3_drop_noreq", {31'b0, req_valid}, 32'd0);
        step();
        check("t3_drop_bubble", inst_addr, 32'h7fff_fffc);
        step();
        check("t3_req_valid", {31'b0, req_valid}, 32'd1);
        check("t3_req_addr", req_addr, 32'h8000_0100);
        // 4: redirect coincident with the response
        step();
        pulse_redirect(32'h8000_0200);
        check("t4_req_valid", {31'b0, req_valid}, 32'd1);
        check("t4_req_addr", req_addr, 32'h8000_0200);
        check("t4_dropped", inst_addr, 32'h7fff_fffc);
        wait_slot("t4_fetch", 10);
        check("t4_target_data", inst_data, 32'h0200_0013);
        // 5: misaligned target traps without a request
        req_ready = 0;
        pulse_redirect(32'h8000_0102);
        req_ready = 1;
        check("t5_noreq", {31'b0, req_valid}, 32'd0);
        step();
        check("t5_addr", inst_addr, 32'h8000_0102);
        check("t5_trap", {24'b0, trap_bus}, 32'h0000_0001);
        repeat (4) step();
        check("t5_still_trapped", {31'b0, req_valid}, 32'd0);
        // 6: access fault at 0x80000008, then reset mid-WAIT with a late response
        err_addr = 32'h8000_0008;
        pulse_redirect(32'h8000_0000);
        for (int i = 0; i < 40 && !(m_sv && m_st == 8'h02); i++) step();
        check("t6_fault_addr", inst_addr, 32'h8000_0008);
        check("t6_fault_trap", {24'b0, trap_bus}, 32'h0000_0002);
        repeat (4) step();
        check("t6_pc_held", req_addr, 32'h8000_0008);
        check("t6_noreq", {31'b0, req_valid}, 32'd0);
        err_addr = 32'hffff_ffff;
        lat_next = 2;
        pulse_redirect(32'h8000_0000);
        step();
        rst = 0;
        req_ready = 0;
        step();
        rst = 1;
        step(); step();
        check("t6_stale_ignored", inst_addr, 32'h7fff_fffc);
        lat_next = 0;
        req_ready = 1;
        wait_slot("t6_restart", 10);
        check("t6_restart_addr", inst_addr, 32'h8000_0000);
        // random phase
        lat_rand = 1;
        err_addr = 32'h8000_0000 + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        for (int i = 0; i < 4000; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            req_ready = ($urandom_range(0, 3) != 0) && !im_pend;
            redirect  = ($urandom_range(0, 15) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            redirect_pc = 32'h8000_0000 + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc + 32'd2;
            rst = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 199) == 0)
                err_addr = 32'h8000_0000 + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            step();
        end
        rst = 1;
        redirect = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
